// File: rtl/usb_uart_loopback_fifo.sv
// ---------------------------------------------------------------------------
// usb_uart_loopback_fifo
//
// Loopback buffer between usb_uart's host-to-device stream and its
// device-to-host stream. This is a DEPTH x WIDTH circular buffer that feeds a
// registered output stage. A push and a pop can happen in the same cycle, so
// the buffer sustains one byte per cycle. A run-time mode transforms each
// byte as it moves into the output register.
//
// Ports
//   clk_48mhz  in   1        sole clock, rising edge
//   reset      in   1        asynchronous, active-high
//   rx_data    in   WIDTH    incoming data (usb_uart.uart_out_data)
//   rx_valid   in   1        incoming data valid
//   rx_ready   out  1        buffer can accept (~full)
//   tx_data    out  WIDTH    outgoing data (registered)
//   tx_valid   out  1        outgoing data valid (registered)
//   tx_ready   in   1        downstream accepts outgoing data
//   mode       in   2        0 PASS, 1 UPPER, 2 INVERT, 3 HOLD
//   level      out  AW+1     entries in buffer, excluding output register
//   full       out  1        level == DEPTH
//   empty      out  1        level == 0
// ---------------------------------------------------------------------------
module usb_uart_loopback_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_48mhz,
   input  logic             reset,
   input  logic [WIDTH-1:0] rx_data,
   input  logic             rx_valid,
   output logic             rx_ready,
   output logic [WIDTH-1:0] tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   input  logic [1:0]       mode,
   output logic [AW:0]      level,
   output logic             full,
   output logic             empty
);

   localparam int LW = AW + 1;

   localparam logic [1:0] MODE_PASS   = 2'd0;
   localparam logic [1:0] MODE_UPPER  = 2'd1;
   localparam logic [1:0] MODE_INVERT = 2'd2;
   localparam logic [1:0] MODE_HOLD   = 2'd3;

   // Byte transform applied as data moves into the output register.
   // Upper-casing only makes sense for 8-bit characters; other widths pass through.
   function automatic logic [WIDTH-1:0] xform(input logic [WIDTH-1:0] d,
                                              input logic [1:0]       m);
      logic [WIDTH-1:0] r;
      r = d;
      case (m)
         MODE_PASS: r = d;
         MODE_UPPER: begin
            if ((WIDTH == 8) && (d >= WIDTH'(8'h61)) && (d <= WIDTH'(8'h7A))) begin
               r = d - WIDTH'(8'h20);
            end else begin
               r = d;
            end
         end
         MODE_INVERT: r = ~d;
         MODE_HOLD: r = d;
         default: r = d;
      endcase
      return r;
   endfunction

   logic [1:0]       rst_sync_r;
   logic             rst_s;
   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [LW-1:0]    level_r;
   logic [LW-1:0]    level_nxt_s;
   logic             full_r;
   logic             empty_r;
   logic [WIDTH-1:0] tx_data_r;
   logic             tx_valid_r;
   logic             push_s;
   logic             load_s;

   // Reset synchronizer. Assertion takes effect immediately; release is
   // aligned to the clock so that every flop leaves reset on the same edge.
   always_ff @(posedge clk_48mhz or posedge reset) begin
      if (reset) begin
         rst_sync_r <= 2'b11;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b0};
      end
   end

   assign rst_s = rst_sync_r[1];

   // rx_ready comes from the registered full flag. When a load frees a slot
   // in a full buffer, rx_ready rises one cycle later.
   assign push_s = rx_valid & ~full_r;
   assign load_s = ~empty_r & (mode != MODE_HOLD) & (~tx_valid_r | tx_ready);

   // Next occupancy. A push and a load in the same cycle cancel out.
   always_comb begin
      level_nxt_s = level_r;
      case ({push_s, load_s})
         2'b10:   level_nxt_s = level_r + LW'(1);
         2'b01:   level_nxt_s = level_r - LW'(1);
         default: level_nxt_s = level_r;
      endcase
   end

   // Storage array. Its contents are deliberately left out of reset.
   always_ff @(posedge clk_48mhz) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= rx_data;
      end
   end

   // Pointers, occupancy and status flags. The pointers wrap naturally at DEPTH.
   always_ff @(posedge clk_48mhz or posedge rst_s) begin
      if (rst_s) begin
         wr_ptr_r <= AW'(0);
         rd_ptr_r <= AW'(0);
         level_r  <= LW'(0);
         full_r   <= 1'b0;
         empty_r  <= 1'b1;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (load_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         level_r <= level_nxt_s;
         full_r  <= (level_nxt_s == LW'(DEPTH));
         empty_r <= (level_nxt_s == LW'(0));
      end
   end

   // Output register. It holds its data while stalled, and tx_data keeps the
   // last byte after the handshake completes.
   always_ff @(posedge clk_48mhz or posedge rst_s) begin
      if (rst_s) begin
         tx_data_r  <= WIDTH'(0);
         tx_valid_r <= 1'b0;
      end else if (load_s) begin
         tx_data_r  <= xform(mem_r[rd_ptr_r], mode);
         tx_valid_r <= 1'b1;
      end else if (tx_valid_r & tx_ready) begin
         tx_valid_r <= 1'b0;
      end else begin
         tx_valid_r <= tx_valid_r;
      end
   end

   assign rx_ready = ~full_r;
   assign tx_data  = tx_data_r;
   assign tx_valid = tx_valid_r;
   assign level    = level_r;
   assign full     = full_r;
   assign empty    = empty_r;

endmodule
